sram_banked_rr_pipe: RTL
========================

// Module: sram_banked_rr_pipe
// PURPOSE
//  Parametrised successor to the generic single-port SRAM wrapper. Adds a val/rdy request/response
//  interface, byte-masked writes, low-order bank interleaving over NUM_BANKS behavioural arrays and
//  a 2-entry response queue, so caches can apply backpressure without losing SRAM read data.
//  Sits between cache control and the data/tag arrays.
// PARAMETERS
//  NUM_BITS   128  data word width; multiple of 8
//  NUM_WORDS  256  total words; power of 2
//  NUM_BANKS  2    banks; power of 2, divides NUM_WORDS; bank = addr[BSEL-1:0]
//  TAG_BITS   8    opaque request tag returned with the response
// PORTS
//  clk         in   1                 clock, all state on posedge
//  reset       in   1                 asynchronous, active-low reset
//  req_val     in   1                 request valid
//  req_rdy     out  1                 request ready
//  req_type    in   1                 0 = read, 1 = write (sram_pkg::req_t)
//  req_addr    in   $clog2(NUM_WORDS) word address
//  req_data    in   NUM_BITS          write data
//  req_wmask   in   NUM_BITS/8        byte write enable, bit i -> data[8i+:8]
//  req_tag     in   TAG_BITS          opaque tag
//  resp_val    out  1                 response valid
//  resp_rdy    in   1                 response ready
//  resp_type   out  1                 echoed req_type
//  resp_data   out  NUM_BITS          read data; 0 for write responses
//  resp_tag    out  TAG_BITS          echoed tag
// BEHAVIOUR
//  - Reset (reset=0): resp_val=0, req_rdy=0, queue count=0, in-flight flag=0; memory NOT cleared.
//    req_rdy rises the first cycle after reset deasserts. Reset mid-operation drops in-flight and
//    queued responses; a request whose accepting edge coincides with reset asserted is not performed.
//  - Accept = req_val && req_rdy. Exactly one bank enabled on accept; other banks idle (no CE).
//  - Write: at the accepting edge, bytes with wmask[i]=1 updated; wmask=0 leaves word unchanged.
//  - Read: array data available the cycle after accept (latency 1). Read the cycle after a write to
//    the same address returns the new data.
//  - Response path: in-flight stage feeds a 2-entry FIFO with bypass; if FIFO empty and resp_rdy=1,
//    the response is presented combinationally in cycle t+1 (resp_val=1 in t+1 for accept in t).
//    Otherwise it is enqueued and held stable until resp_val && resp_rdy.
//  - Credits: req_rdy = (inflight + count) < 2, no combinational path from resp_rdy or req_val.
//    Sustains 1 request/cycle when resp_rdy held high; never overflows the FIFO.
//  - Simultaneous enqueue and dequeue on a full-minus-one FIFO: count unchanged, order preserved.
//  - Responses strictly in request order.
// CONFIGURATION
//  SRAM_WRITE_RESP_EN defined: writes return a response (resp_type=1, resp_data=0, tag echoed) and
//  consume a credit. Undefined: writes complete silently, use no credit, only reads respond.
// STRUCTURE
//  - sram_pkg: typedef enum logic {REQ_READ, REQ_WRITE} req_t; resp struct {type, data, tag} typedef;
//    localparam QUEUE_DEPTH = 2.
//  - Sub-module sram_bank_array (NUM_BITS, NUM_WORDS/NUM_BANKS): behavioural 1RW array with
//    cen/gwen active-low and byte mask, registered q; instantiated NUM_BANKS times in a generate loop.
//  - Top holds credit counter, in-flight bank/tag register, output mux and response FIFO.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> resp_val=0, req_rdy=0; release -> req_rdy=1 next cycle.
//  2 Write addr 0x05 data 0xA5..A5 wmask all 1s tag 3, then read 0x05 tag 4 -> resp_data 0xA5..A5,
//    tag 4 (plus write resp tag 3 first when SRAM_WRITE_RESP_EN).
//  3 Byte mask: write 0x11..11 to 0x10, then write 0xFF..FF wmask=16'h0001, read -> 0x11..11FF.
//  4 Bank interleave (NUM_BANKS=2): write addr 6,7 distinct data; read 7,6 back-to-back ->
//    correct data in order, one response per cycle, req_rdy stays 1 with resp_rdy=1.
//  5 Backpressure: resp_rdy=0, issue 3 reads -> only 2 accepted, req_rdy=0; raise resp_rdy ->
//    2 responses in order, then third accepted; no data lost.
//  6 Reset mid-stream: 2 reads queued, pulse reset -> resp_val=0 immediately; memory retains prior writes.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types for the banked SRAM pipeline: request kind, response payload, queue depth.
package sram_pkg;

    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned DATA_BITS   = 128;
    localparam int unsigned TAG_W       = 8;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_t;

    typedef struct packed {
        req_t                 rtype;
        logic [DATA_BITS-1:0] data;
        logic [TAG_W-1:0]     tag;
    } resp_t;

endpackage

// File: rtl/sram_bank_array.sv
// Behavioural 1RW SRAM bank: active-low chip enable and global write enable,
// byte write mask, registered read data that holds between reads.
module sram_bank_array #(
    parameter int unsigned NUM_BITS  = 128,
    parameter int unsigned NUM_WORDS = 128
) (
    input  logic                         clk,
    input  logic                         cen,
    input  logic                         gwen,
    input  logic [NUM_BITS/8-1:0]        wmask,
    input  logic [$clog2(NUM_WORDS)-1:0] addr,
    input  logic [NUM_BITS-1:0]          d,
    output logic [NUM_BITS-1:0]          q
);

    localparam int unsigned NUM_BYTES = NUM_BITS / 8;

    logic [NUM_BITS-1:0] mem [NUM_WORDS];

    // Storage is intentionally not reset; contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!gwen) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (wmask[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_banked_rr_pipe.sv
// Banked SRAM with val/rdy request and response ports and a 2-entry bypassable response queue.
// Define SRAM_WRITE_RESP_EN to have writes return a response and consume a credit.
module sram_banked_rr_pipe
    import sram_pkg::*;
#(
    parameter int unsigned NUM_BITS  = DATA_BITS,
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned TAG_BITS  = TAG_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_val,
    output logic                         req_rdy,
    input  req_t                         req_type,
    input  logic [$clog2(NUM_WORDS)-1:0] req_addr,
    input  logic [NUM_BITS-1:0]          req_data,
    input  logic [NUM_BITS/8-1:0]        req_wmask,
    input  logic [TAG_BITS-1:0]          req_tag,
    output logic                         resp_val,
    input  logic                         resp_rdy,
    output req_t                         resp_type,
    output logic [NUM_BITS-1:0]          resp_data,
    output logic [TAG_BITS-1:0]          resp_tag
);

    localparam int unsigned BSEL       = $clog2(NUM_BANKS);
    localparam int unsigned BANK_W     = (BSEL == 0) ? 1 : BSEL;
    localparam int unsigned BANK_WORDS = NUM_WORDS / NUM_BANKS;
    localparam int unsigned ROW_W      = $clog2(BANK_WORDS);
    localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned CR_W       = CNT_W + 1;
    localparam int unsigned PTR_W      = $clog2(QUEUE_DEPTH);

    logic                accept;
    logic                needs_resp;
    logic [BANK_W-1:0]   req_bank;
    logic [ROW_W-1:0]    req_row;
    logic [NUM_BITS-1:0] bank_q [NUM_BANKS];

    logic                infl;
    logic [BANK_W-1:0]   infl_bank;
    req_t                infl_type;
    logic [TAG_BITS-1:0] infl_tag;

    resp_t               fifo [QUEUE_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;

    resp_t               cur_resp;
    resp_t               out_resp;
    logic                enq;
    logic                deq_fifo;
    logic                infl_n;
    logic [CNT_W-1:0]    count_n;
    logic [CR_W-1:0]     credits_n;
    logic                rdy_n;

    assign accept   = req_val && req_rdy;
    assign req_bank = BANK_W'(req_addr % NUM_BANKS);
    assign req_row  = ROW_W'(req_addr >> BSEL);

`ifdef SRAM_WRITE_RESP_EN
    assign needs_resp = 1'b1;
`else
    assign needs_resp = (req_type == REQ_READ);
`endif

    // Low-order interleave: only the addressed bank sees CE on an accept.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        sram_bank_array #(
            .NUM_BITS  (NUM_BITS),
            .NUM_WORDS (BANK_WORDS)
        ) u_bank (
            .clk   (clk),
            .cen   (!(accept && (req_bank == BANK_W'(g)))),
            .gwen  (req_type != REQ_WRITE),
            .wmask (req_wmask),
            .addr  (req_row),
            .d     (req_data),
            .q     (bank_q[g])
        );
    end

    // Response selection, queue control and next-cycle credit computation.
    always_comb begin
        cur_resp.rtype = infl_type;
        cur_resp.tag   = infl_tag;
        cur_resp.data  = (infl_type == REQ_READ) ? bank_q[infl_bank] : '0;

        out_resp  = (count != '0) ? fifo[head] : cur_resp;
        resp_val  = infl || (count != '0);
        resp_type = out_resp.rtype;
        resp_data = out_resp.data;
        resp_tag  = out_resp.tag;

        enq       = infl && !((count == '0) && resp_rdy);
        deq_fifo  = (count != '0) && resp_rdy;
        wr_ptr    = head + PTR_W'(count);
        count_n   = count + CNT_W'(enq) - CNT_W'(deq_fifo);
        infl_n    = accept && needs_resp;
        credits_n = CR_W'(infl_n) + CR_W'(count_n);
        rdy_n     = credits_n < CR_W'(QUEUE_DEPTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            infl      <= 1'b0;
            infl_bank <= '0;
            infl_type <= REQ_READ;
            infl_tag  <= '0;
            head      <= '0;
            count     <= '0;
            req_rdy   <= 1'b0;
        end else begin
            infl    <= infl_n;
            count   <= count_n;
            req_rdy <= rdy_n;
            if (accept) begin
                infl_bank <= req_bank;
                infl_type <= req_type;
                infl_tag  <= req_tag;
            end
            if (deq_fifo) head <= head + PTR_W'(1);
        end
    end

    // Queue payload needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (enq) fifo[wr_ptr] <= cur_resp;
    end

endmodule
